// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: interrupt scheduler states, register addresses,
// the timer interrupt bit position and the exception vector.
package cp0_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_BLOCK = 2'd2
  } int_state_t;

  localparam logic [4:0] CP0_BADVADDR = 5'd8;
  localparam logic [4:0] CP0_COUNT    = 5'd9;
  localparam logic [4:0] CP0_COMPARE  = 5'd11;
  localparam logic [4:0] CP0_STATUS   = 5'd12;
  localparam logic [4:0] CP0_CAUSE    = 5'd13;
  localparam logic [4:0] CP0_EPC      = 5'd14;

  localparam int IP_TIMER_BIT = 7;

  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

endpackage

// File: rtl/cp0_sync_n.sv
// Multi-bit flop-chain synchronizer for independent level-sensitive lines.
// Latency is STAGES edges; no backpressure.
module cp0_sync_n #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] r_chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/cp0_int_ctrl.sv
// CP0 interrupt/timer controller: synchronizes hardware lines, runs Count/Compare,
// and schedules interrupt acceptance onto a committing WB instruction.
module cp0_int_ctrl
  import cp0_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  ext_int,
  input  logic [1:0]  sw_ip,
  input  logic [7:0]  status_im,
  input  logic        status_ie,
  input  logic        status_exl,
  input  logic        count_we,
  input  logic        compare_we,
  input  logic [31:0] mtc0_data,
  input  logic        commit_valid,
  input  logic        commit_exception,
  output logic        int_take,
  output logic [7:0]  cause_ip,
  output logic        cause_ti,
  output logic [31:0] count_out,
  output logic [31:0] compare_out
);

  logic [5:0]  w_hw;
  logic        r_tick;
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_ti;
  logic        w_pend;
  int_state_t  r_state;
  int_state_t  w_state_nxt;

  cp0_sync_n #(
    .WIDTH  (6),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ext_int),
    .q     (w_hw)
  );

  // hw[5] shares its IP slot with the timer flag.
  always_comb begin
    cause_ip               = {w_hw, sw_ip};
    cause_ip[IP_TIMER_BIT] = w_hw[5] | r_ti;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick    <= 1'b0;
      r_count   <= '0;
      r_compare <= COMPARE_RST;
      r_ti      <= 1'b0;
    end else begin
      if (count_we) begin
        r_count <= mtc0_data;
        r_tick  <= 1'b0;
      end else begin
        r_count <= r_count + {31'd0, r_tick};
        r_tick  <= ~r_tick;
      end
      if (compare_we) begin
        r_compare <= mtc0_data;
        r_ti      <= 1'b0;
      end else if (r_count == r_compare) begin
        r_ti <= 1'b1;
      end
    end
  end

  assign w_pend   = (|(cause_ip & status_im)) & status_ie & ~status_exl;
  assign int_take = (r_state == ST_ARMED) & w_pend & commit_valid & ~commit_exception;

  // BLOCK idles one cycle so a late EXL update cannot cause a back-to-back take.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_pend) w_state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (!w_pend)       w_state_nxt = ST_IDLE;
        else if (int_take) w_state_nxt = ST_BLOCK;
      end
      ST_BLOCK: w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign cause_ti    = r_ti;
  assign count_out   = r_count;
  assign compare_out = r_compare;

endmodule
